// File: rtl/fetch_pkg.sv
// Shared constants, FSM state encodings and FIFO payload type for the fetch stage.
package fetch_pkg;
   localparam int unsigned INST_WIDTH = 32;
   localparam int unsigned PC_STEP    = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_FETCH = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   typedef struct packed {
      logic [INST_WIDTH-1:0] pc;
      logic [INST_WIDTH-1:0] inst;
   } fetch_entry_t;
endpackage

// File: rtl/fetch_buffer.sv
// Synchronous FIFO of {pc, inst} entries between fetch and decode.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int unsigned DEPTH = 2,
   localparam int unsigned CW   = $clog2(DEPTH + 1)
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  push,
   input  logic                  pop,
   input  logic                  flush,
   input  logic [INST_WIDTH-1:0] push_pc,
   input  logic [INST_WIDTH-1:0] push_inst,
   output logic                  head_valid,
   output logic [INST_WIDTH-1:0] head_pc,
   output logic [INST_WIDTH-1:0] head_inst,
   output logic [CW-1:0]         count
);
   localparam int unsigned PW = $clog2(DEPTH);

   fetch_entry_t storage [DEPTH];
   fetch_entry_t wr_entry;
   logic [PW-1:0] wr_ptr;
   logic [PW-1:0] rd_ptr;
   logic          do_pop;

   assign wr_entry.pc   = push_pc;
   assign wr_entry.inst = push_inst;
   assign do_pop        = pop & (count != '0);

   assign head_valid = (count != '0);
   assign head_pc    = storage[rd_ptr].pc;
   assign head_inst  = storage[rd_ptr].inst;

   // Storage is cleared on reset so the head outputs read zero afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         for (int i = 0; i < int'(DEPTH); i++) storage[i] <= '0;
      end else if (flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            storage[wr_ptr] <= wr_entry;
            wr_ptr          <= wr_ptr + PW'(1);
         end
         if (do_pop) rd_ptr <= rd_ptr + PW'(1);
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: ;
         endcase
      end
   end
endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: single-outstanding instruction reads, PC advance control, jump flush/drain.
module instruction_fetch
   import fetch_pkg::*;
#(
   parameter int unsigned BUFFER_DEPTH = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] pc,
   input  logic        jump_en,
   output logic        pc_enable,
   output logic        mem_req,
   output logic [31:0] mem_addr,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata,
   output logic        inst_valid,
   output logic [31:0] inst,
   output logic [31:0] inst_pc,
   input  logic        inst_ready
);
   localparam int unsigned CW  = $clog2(BUFFER_DEPTH + 1);
   localparam int unsigned CNW = CW + 1;

   logic [1:0]     state;
   logic [1:0]     state_next;
   logic [31:0]    addr_q;
   logic [31:0]    addr_next;
   logic [CW-1:0]  count;
   logic [CNW-1:0] count_next;
   logic           push;
   logic           pop;

   assign pop        = inst_valid & inst_ready & ~jump_en;
   assign push       = (state == ST_FETCH) & mem_ready & ~jump_en;
   assign pc_enable  = jump_en | push;
   assign count_next = CNW'(count) + CNW'(1) - CNW'(pop);
   assign mem_addr   = addr_q;

   // Next-state and address update.
   always_comb begin
      state_next = state;
      addr_next  = addr_q;
      case (state)
         ST_IDLE: begin
            if ((count < CW'(BUFFER_DEPTH)) && !jump_en) begin
               addr_next  = pc;
               state_next = ST_FETCH;
            end
         end
         ST_FETCH: begin
            if (jump_en) begin
               state_next = mem_ready ? ST_IDLE : ST_DRAIN;
            end else if (mem_ready) begin
               if (count_next < CNW'(BUFFER_DEPTH)) addr_next = addr_q + 32'(PC_STEP);
               else                                 state_next = ST_IDLE;
            end
         end
         ST_DRAIN: begin
            if (mem_ready) state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_IDLE;
         addr_q  <= '0;
         mem_req <= 1'b0;
      end else begin
         state   <= state_next;
         addr_q  <= addr_next;
         mem_req <= (state_next != ST_IDLE);
      end
   end

   fetch_buffer #(.DEPTH(BUFFER_DEPTH)) u_buffer (
      .clk        (clk),
      .reset      (reset),
      .push       (push),
      .pop        (pop),
      .flush      (jump_en),
      .push_pc    (addr_q),
      .push_inst  (mem_rdata),
      .head_valid (inst_valid),
      .head_pc    (inst_pc),
      .head_inst  (inst),
      .count      (count)
   );
endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch with a PC-register model and an address-keyed memory.
module tb_instruction_fetch;
   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] pc;
   logic        jump_en;
   logic [31:0] jump_target;
   logic        pc_enable;
   logic        mem_req;
   logic [31:0] mem_addr;
   logic        mem_ready;
   logic [31:0] mem_rdata;
   logic        inst_valid;
   logic [31:0] inst;
   logic [31:0] inst_pc;
   logic        inst_ready;
   logic        pc_force;
   logic [31:0] pc_force_val;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   // Instruction word is the address with a fixed pattern XORed into the top half.
   assign mem_rdata = mem_addr ^ 32'hA5A5_0000;

   // PC register: forced by the bench, else advance by 4 or load the jump target.
   always @(posedge clk) begin
      if (pc_force)       pc <= pc_force_val;
      else if (pc_enable) pc <= jump_en ? jump_target : pc + 32'd4;
   end

   instruction_fetch #(.BUFFER_DEPTH(2)) dut (
      .clk        (clk),
      .reset      (reset),
      .pc         (pc),
      .jump_en    (jump_en),
      .pc_enable  (pc_enable),
      .mem_req    (mem_req),
      .mem_addr   (mem_addr),
      .mem_ready  (mem_ready),
      .mem_rdata  (mem_rdata),
      .inst_valid (inst_valid),
      .inst       (inst),
      .inst_pc    (inst_pc),
      .inst_ready (inst_ready)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset(input logic [31:0] start_pc);
      reset        = 1'b1;
      pc_force     = 1'b1;
      pc_force_val = start_pc;
      tick();
      tick();
      pc_force = 1'b0;
      reset    = 1'b0;
   endtask

   task automatic test_reset();
      jump_en = 0; jump_target = 0; mem_ready = 1; inst_ready = 1;
      do_reset(32'h100);
      #1;
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0)      begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL reset_pc_enable: got %b want 0", pc_enable); end
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL reset_inst_valid: got %b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0)          begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
      n_cmp++; if (inst_pc !== 32'h0)       begin n_err++; $display("FAIL reset_inst_pc: got %h want 0", inst_pc); end
   endtask

   task automatic test_stream();
      tick();
      n_cmp++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL stream_req0: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== 32'h100)    begin n_err++; $display("FAIL stream_addr0: got %h want 00000100", mem_addr); end
      n_cmp++; if (pc_enable !== 1'b1)      begin n_err++; $display("FAIL stream_pcen0: got %b want 1", pc_enable); end
      tick();
      n_cmp++; if (mem_addr !== 32'h104)    begin n_err++; $display("FAIL stream_addr1: got %h want 00000104", mem_addr); end
      n_cmp++; if (inst_valid !== 1'b1)     begin n_err++; $display("FAIL stream_valid1: got %b want 1", inst_valid); end
      n_cmp++; if (inst_pc !== 32'h100)     begin n_err++; $display("FAIL stream_ipc1: got %h want 00000100", inst_pc); end
      n_cmp++; if (inst !== 32'hA5A5_0100)  begin n_err++; $display("FAIL stream_inst1: got %h want a5a50100", inst); end
      n_cmp++; if (pc_enable !== 1'b1)      begin n_err++; $display("FAIL stream_pcen1: got %b want 1", pc_enable); end
      tick();
      n_cmp++; if (mem_addr !== 32'h108)    begin n_err++; $display("FAIL stream_addr2: got %h want 00000108", mem_addr); end
      n_cmp++; if (inst_pc !== 32'h104)     begin n_err++; $display("FAIL stream_ipc2: got %h want 00000104", inst_pc); end
      n_cmp++; if (inst !== 32'hA5A5_0104)  begin n_err++; $display("FAIL stream_inst2: got %h want a5a50104", inst); end
      n_cmp++; if (pc !== 32'h108)          begin n_err++; $display("FAIL stream_pc: got %h want 00000108", pc); end
   endtask

   task automatic test_backpressure();
      inst_ready = 0; mem_ready = 1;
      do_reset(32'h100);
      tick();
      tick();
      n_cmp++; if (inst_pc !== 32'h100)     begin n_err++; $display("FAIL bp_head0: got %h want 00000100", inst_pc); end
      tick();
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL bp_idle_req: got %b want 0", mem_req); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL bp_idle_pcen: got %b want 0", pc_enable); end
      tick();
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL bp_idle_req2: got %b want 0", mem_req); end
      n_cmp++; if (inst_pc !== 32'h100)     begin n_err++; $display("FAIL bp_head_hold: got %h want 00000100", inst_pc); end
      inst_ready = 1; mem_ready = 0;
      tick();
      n_cmp++; if (inst_pc !== 32'h104)     begin n_err++; $display("FAIL bp_head1: got %h want 00000104", inst_pc); end
      n_cmp++; if (inst !== 32'hA5A5_0104)  begin n_err++; $display("FAIL bp_inst1: got %h want a5a50104", inst); end
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL bp_req_after_pop: got %b want 0", mem_req); end
      tick();
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL bp_empty: got %b want 0", inst_valid); end
      n_cmp++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL bp_resume_req: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== 32'h108)    begin n_err++; $display("FAIL bp_resume_addr: got %h want 00000108", mem_addr); end
   endtask

   task automatic test_jump_drain();
      tick();
      jump_en = 1; jump_target = 32'h400;
      #1;
      n_cmp++; if (pc_enable !== 1'b1)      begin n_err++; $display("FAIL jd_pcen: got %b want 1", pc_enable); end
      tick();
      jump_en = 0;
      #1;
      n_cmp++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL jd_drain_req: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== 32'h108)    begin n_err++; $display("FAIL jd_drain_addr: got %h want 00000108", mem_addr); end
      n_cmp++; if (pc !== 32'h400)          begin n_err++; $display("FAIL jd_pc: got %h want 00000400", pc); end
      tick();
      mem_ready = 1;
      #1;
      n_cmp++; if (mem_addr !== 32'h108)    begin n_err++; $display("FAIL jd_drain_addr2: got %h want 00000108", mem_addr); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL jd_drain_pcen: got %b want 0", pc_enable); end
      tick();
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL jd_dropped: got %b want 0", inst_valid); end
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL jd_idle_req: got %b want 0", mem_req); end
      tick();
      n_cmp++; if (mem_addr !== 32'h400)    begin n_err++; $display("FAIL jd_new_addr: got %h want 00000400", mem_addr); end
      n_cmp++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL jd_new_req: got %b want 1", mem_req); end
   endtask

   task automatic test_jump_with_ready();
      tick();
      n_cmp++; if (inst_pc !== 32'h400)     begin n_err++; $display("FAIL jr_head: got %h want 00000400", inst_pc); end
      jump_en = 1; jump_target = 32'h800;
      #1;
      n_cmp++; if (pc_enable !== 1'b1)      begin n_err++; $display("FAIL jr_pcen: got %b want 1", pc_enable); end
      tick();
      jump_en = 0;
      #1;
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL jr_flushed: got %b want 0", inst_valid); end
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL jr_idle_req: got %b want 0", mem_req); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL jr_single_pcen: got %b want 0", pc_enable); end
      n_cmp++; if (pc !== 32'h800)          begin n_err++; $display("FAIL jr_pc: got %h want 00000800", pc); end
      tick();
      n_cmp++; if (mem_addr !== 32'h800)    begin n_err++; $display("FAIL jr_new_addr: got %h want 00000800", mem_addr); end
   endtask

   task automatic test_double_jump();
      mem_ready = 0; jump_en = 1; jump_target = 32'h900;
      tick();
      jump_en = 1; jump_target = 32'hA00;
      #1;
      n_cmp++; if (pc_enable !== 1'b1)      begin n_err++; $display("FAIL dj_pcen2: got %b want 1", pc_enable); end
      tick();
      jump_en = 0; mem_ready = 1;
      #1;
      n_cmp++; if (mem_req !== 1'b1)        begin n_err++; $display("FAIL dj_drain_req: got %b want 1", mem_req); end
      n_cmp++; if (mem_addr !== 32'h800)    begin n_err++; $display("FAIL dj_drain_addr: got %h want 00000800", mem_addr); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL dj_drain_pcen: got %b want 0", pc_enable); end
      n_cmp++; if (pc !== 32'hA00)          begin n_err++; $display("FAIL dj_pc: got %h want 00000a00", pc); end
      tick();
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL dj_idle_req: got %b want 0", mem_req); end
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL dj_dropped: got %b want 0", inst_valid); end
      tick();
      n_cmp++; if (mem_addr !== 32'hA00)    begin n_err++; $display("FAIL dj_new_addr: got %h want 00000a00", mem_addr); end
   endtask

   task automatic test_wrap_and_reset();
      mem_ready = 1; inst_ready = 1; jump_en = 0;
      do_reset(32'hFFFF_FFFC);
      tick();
      n_cmp++; if (mem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_addr0: got %h want fffffffc", mem_addr); end
      tick();
      n_cmp++; if (mem_addr !== 32'h0)      begin n_err++; $display("FAIL wrap_addr1: got %h want 00000000", mem_addr); end
      n_cmp++; if (inst_pc !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_ipc: got %h want fffffffc", inst_pc); end
      reset = 1;
      tick();
      n_cmp++; if (mem_req !== 1'b0)        begin n_err++; $display("FAIL mid_reset_req: got %b want 0", mem_req); end
      n_cmp++; if (mem_addr !== 32'h0)      begin n_err++; $display("FAIL mid_reset_addr: got %h want 0", mem_addr); end
      n_cmp++; if (pc_enable !== 1'b0)      begin n_err++; $display("FAIL mid_reset_pcen: got %b want 0", pc_enable); end
      n_cmp++; if (inst_valid !== 1'b0)     begin n_err++; $display("FAIL mid_reset_valid: got %b want 0", inst_valid); end
      n_cmp++; if (inst !== 32'h0)          begin n_err++; $display("FAIL mid_reset_inst: got %h want 0", inst); end
      n_cmp++; if (inst_pc !== 32'h0)       begin n_err++; $display("FAIL mid_reset_ipc: got %h want 0", inst_pc); end
      reset = 0;
   endtask

   initial begin
      reset = 1; pc_force = 1; pc_force_val = 32'h100;
      jump_en = 0; jump_target = 0; mem_ready = 0; inst_ready = 0;
      test_reset();
      test_stream();
      test_backpressure();
      test_jump_drain();
      test_jump_with_ready();
      test_double_jump();
      test_wrap_and_reset();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/instruction_fetch.md
# instruction_fetch

Fetch stage between the program-counter register and decode. It issues one 32-bit instruction read at a time to instruction memory and controls the PC register's `pc_enable`. Returned instructions, tagged with their address, go into a small FIFO that decode drains with a valid/ready handshake. On a taken jump it flushes the FIFO and safely retires any memory read still in flight.

## Interface
- `BUFFER_DEPTH`, default 2: FIFO entries; power of two, ≥2.
- `clk`  in  1: single clock; all state updates on rising edge.
- `reset`  in  1: synchronous, active-high.
- `pc`  in  32: current PC register output.
- `jump_en`  in  1: taken jump/branch this cycle; PC register loads the jump target when `pc_enable` is high.
- `pc_enable`  out  1: enable for the PC register (advance by 4, or load jump target).
- `mem_req`  out  1: read request to instruction memory.
- `mem_addr`  out  32: read address; stable while `mem_req` is high.
- `mem_ready`  in  1: read completes this cycle; `mem_rdata` is valid.
- `mem_rdata`  in  32: instruction word.
- `inst_valid`  out  1: FIFO head valid.
- `inst`  out  32: FIFO head instruction.
- `inst_pc`  out  32: FIFO head address.
- `inst_ready`  in  1: decode accepts head this cycle.

## Operation
- **IDLE** (reset state): `mem_req` is 0. If `count < BUFFER_DEPTH` and `!jump_en`, latch `addr_q <= pc` and go to FETCH.
- **FETCH**: `mem_req` is 1 and `mem_addr = addr_q`.
  - `mem_ready & !jump_en`: push {addr_q, mem_rdata} and pulse `pc_enable`. Compute `count_next = count + 1 - pop`. If `count_next < BUFFER_DEPTH`, set `addr_q <= addr_q + 4` and stay in FETCH; otherwise go to IDLE.
  - `jump_en & mem_ready`: discard the data, flush, go to IDLE.
  - `jump_en & !mem_ready`: flush, go to DRAIN. `addr_q` is held.
- **DRAIN**: `mem_req` is 1 and `mem_addr = addr_q` (the stale address).
  - `mem_ready`: drop the data, go to IDLE. `pc_enable` is not asserted for this completion.
  - `jump_en` in DRAIN: flush (FIFO is already empty), assert `pc_enable`, stay in DRAIN.
- `pc_enable = jump_en | (state == FETCH & mem_ready & !jump_en)`. The jump target is always accepted in the same cycle.
- **Pop**: `inst_valid & inst_ready & !jump_en`.
- **Flush**: `count <= 0`, pointers reset. A same-cycle pop is ignored, and decode must discard its own stage.
- **FIFO overflow**: impossible. A push happens only in FETCH, and FETCH is entered or kept only when `count_next < BUFFER_DEPTH`. Push with pop on a full FIFO cannot occur. Push with pop on a partly filled FIFO leaves `count` unchanged.
- **Address arithmetic**: modulo 2^32; 0xFFFF_FFFC + 4 wraps to 0.
- **Alignment**: `mem_addr[1:0]` always equals `pc[1:0]` as latched; no alignment check in this block.

## Timing
- Reset values: state IDLE, `count = 0`, `addr_q = 0`, `mem_req = 0`, `pc_enable = 0`, `inst_valid = 0`, `inst = 0`, `inst_pc = 0`.
- Only combinational paths: `jump_en` → `pc_enable`, and `mem_ready` → `pc_enable`.
- First request: the cycle after reset deasserts, IDLE latches `pc`; `mem_req` rises the following cycle.
- With zero-wait memory (`mem_ready` tied high), decode always ready, and `BUFFER_DEPTH = 2`: one instruction per cycle sustained.
- `inst_valid` rises one cycle after the completing `mem_ready`.
- After a jump, the first request at the new PC is at least 2 cycles later (IDLE latch, then FETCH); it waits longer if DRAIN is pending.
- Reset mid-transaction: the block returns to IDLE immediately. Memory must tolerate `mem_req` dropping; a late `mem_ready` is ignored in IDLE.

## Structure
- `fetch_pkg`: state enum (IDLE, FETCH, DRAIN), `INST_WIDTH = 32`, `PC_STEP = 4`.
- Sub-module `fetch_buffer`: sync FIFO with parameterized depth, {pc, inst} payload, `push`, `pop`, `flush`, `count` output. Width of `count` is `$clog2(BUFFER_DEPTH + 1)`.
- The top level holds the FSM, `addr_q`, and the `pc_enable` logic only.

## Test plan
- Reset with `pc = 0x100`, `mem_ready = 1`, `inst_ready = 1` → `mem_addr` sequence 0x100, 0x104, 0x108 on consecutive cycles; `inst_pc` follows one cycle later with matching `inst`; one `pc_enable` pulse per completion.
- Hold `inst_ready = 0` with zero-wait memory → exactly 2 pushes, then IDLE with `mem_req = 0` and `pc_enable` low. Release `inst_ready` → entries 0x100 and 0x104 delivered in order, fetch resumes at 0x108.
- `jump_en` while FETCH waits at 0x108 (`mem_ready = 0` for 3 cycles) → `pc_enable = 1` in the jump cycle, FIFO emptied, `mem_addr` stays 0x108 through DRAIN. The completion is dropped (`inst_valid` stays 0). Next request at the new `pc` (e.g. 0x400).
- `jump_en` in the same cycle as `mem_ready` and `inst_ready` → no push, no pop, `count = 0`, state IDLE, single `pc_enable`.
- Second `jump_en` during DRAIN → `pc_enable` again, stays in DRAIN until `mem_ready`, then fetches from the latest `pc`.
- `pc = 0xFFFF_FFFC` with zero-wait memory → next `mem_addr` is 0x0000_0000. Reset asserted mid-FETCH → all outputs return to their reset values the next cycle.
